serializador_param: RTL and testbench

//  Parametrised parallel-to-serial converter for the serdes TX path. It accepts
//  W-bit words over a valid/ready handshake and buffers one word while the

---
 rtl/serializador_param.sv | 75 +++++++
 tb/tb_serializador_param.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializador_param.sv
// Parallel-to-serial converter with one-word holding buffer.
// Idle fill keeps the serial stream gap-free when no word is pending.
module serializador_param #(
    parameter int             W         = 8,
    parameter bit             MSB_FIRST = 1'b1,
    parameter logic [W-1:0]   IDLE_WORD = W'(8'hBC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out,
    output logic         dk,
    output logic         sof
);

    localparam int          CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  buf_q, buf_d;
    logic          buf_full_q, buf_full_d;
    logic          cur_dk_q, cur_dk_d;
    logic          accept;
    logic          wrap;

    always_comb begin
        accept     = in_valid & ~buf_full_q;
        wrap       = (cnt_q == LAST);
        cnt_d      = wrap ? '0 : cnt_q + CW'(1);
        sr_d       = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cur_dk_d   = cur_dk_q;
        if (wrap) begin
            if (buf_full_q) begin
                sr_d       = buf_q;
                cur_dk_d   = 1'b1;
                buf_full_d = 1'b0;
            end else begin
                sr_d     = IDLE_WORD;
                cur_dk_d = 1'b0;
            end
        end
        // A word accepted on the boundary edge lands in the buffer, never in sr
        if (accept) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q       <= IDLE_WORD;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cur_dk_q   <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cur_dk_q   <= cur_dk_d;
        end
    end

    assign in_ready = ~buf_full_q;
    assign out      = MSB_FIRST ? sr_q[W-1] : sr_q[0];
    assign dk       = cur_dk_q;
    assign sof      = (cnt_q == '0);

endmodule

// File: tb/tb_serializador_param.sv
// Bench for serializador_param: three instances (MSB/LSB W=8, MSB W=10)
// checked against a word-slot model of the serial line.
module tb_serializador_param;

    logic clk;
    logic reset;
    logic v0, v1, v2;
    logic [7:0] d0, d1;
    logic [9:0] d2;
    logic rdy0, rdy1, rdy2;
    logic out0, out1, out2;
    logic dk0, dk1, dk2;
    logic sof0, sof1, sof2;

    int total;
    int bad;

    serializador_param #(.W(8), .MSB_FIRST(1'b1), .IDLE_WORD(8'hBC)) u0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0),
        .in_ready(rdy0), .out(out0), .dk(dk0), .sof(sof0)
    );

    serializador_param #(.W(8), .MSB_FIRST(1'b0), .IDLE_WORD(8'hBC)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .out(out1), .dk(dk1), .sof(sof1)
    );

    serializador_param #(.W(10), .MSB_FIRST(1'b1), .IDLE_WORD(10'h17C)) u2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2),
        .in_ready(rdy2), .out(out2), .dk(dk2), .sof(sof2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line model: each instance carries a word slot of W bit times
    int          mw[3]    = '{8, 8, 10};
    logic        mmsb[3]  = '{1'b1, 1'b0, 1'b1};
    logic [31:0] midle[3] = '{32'hBC, 32'hBC, 32'h17C};
    int          mp[3];
    logic [31:0] mcur[3];
    logic [31:0] mbuf[3];
    logic        mcdk[3];
    logic        mfull[3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            mp[d]    = 0;
            mcur[d]  = midle[d];
            mbuf[d]  = '0;
            mcdk[d]  = 1'b0;
            mfull[d] = 1'b0;
        end
    endfunction

    function automatic logic [3:0] expv(int d);
        int idx;
        idx = mmsb[d] ? (mw[d] - 1 - mp[d]) : mp[d];
        return {mcur[d][idx], mcdk[d], (mp[d] == 0), ~mfull[d]};
    endfunction

    function automatic logic [3:0] obs(int d);
        case (d)
            0:       return {out0, dk0, sof0, rdy0};
            1:       return {out1, dk1, sof1, rdy1};
            default: return {out2, dk2, sof2, rdy2};
        endcase
    endfunction

    task automatic tick();
        logic        vs[3];
        logic [31:0] ds[3];
        logic        acc;
        vs = '{v0, v1, v2};
        ds = '{32'(d0), 32'(d1), 32'(d2)};
        @(posedge clk);
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                acc = vs[d] && !mfull[d];
                if (mp[d] == mw[d] - 1) begin
                    mp[d] = 0;
                    if (mfull[d]) begin
                        mcur[d]  = mbuf[d];
                        mcdk[d]  = 1'b1;
                        mfull[d] = 1'b0;
                    end else begin
                        mcur[d] = midle[d];
                        mcdk[d] = 1'b0;
                    end
                end else begin
                    mp[d]++;
                end
                if (acc) begin
                    mbuf[d]  = ds[d];
                    mfull[d] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] pat;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({out0, dk0, sof0, rdy0} !== 4'b1011) begin
            bad++;
            $display("FAIL reset_u0 got=%b want=1011", {out0, dk0, sof0, rdy0});
        end
        total++;
        if ({out1, dk1, sof1, rdy1} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_u1 got=%b want=0011", {out1, dk1, sof1, rdy1});
        end
        total++;
        if ({out2, dk2, sof2, rdy2} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_u2 got=%b want=0011", {out2, dk2, sof2, rdy2});
        end
        tick();
        tick();
        reset = 1'b0;
        pat = 8'b10111100;
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({out0, dk0, sof0} !== {pat[7 - (i % 8)], 1'b0, (i % 8) == 0}) begin
                bad++;
                $display("FAIL idle_line i=%0d got=%b want=%b", i,
                         {out0, dk0, sof0}, {pat[7 - (i % 8)], 1'b0, (i % 8) == 0});
            end
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs(d) !== expv(d)) begin
                    bad++;
                    $display("FAIL idle_model u%0d got=%b want=%b", d, obs(d), expv(d));
                end
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [7:0] pat;
        int lat;
        int n;
        n = 0;
        while (!(mp[0] == 3 && !mfull[0] && !mcdk[0]) && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL single_align got=timeout want=cnt3");
        end
        v0 = 1'b1;
        d0 = 8'hA5;
        tick();
        v0 = 1'b0;
        d0 = 8'($urandom);
        lat = 1;
        total++;
        if (rdy0 !== 1'b0) begin
            bad++;
            $display("FAIL single_bufull got=%b want=0", rdy0);
        end
        while (dk0 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL single_latency got=%0d want=5", lat);
        end
        pat = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) pat = 8'hBC;
            total++;
            if ({out0, dk0, sof0} !== {pat[7 - (i % 8)], i < 8, (i % 8) == 0}) begin
                bad++;
                $display("FAIL single_bits i=%0d got=%b want=%b", i,
                         {out0, dk0, sof0}, {pat[7 - (i % 8)], i < 8, (i % 8) == 0});
            end
            total++;
            if (obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL single_model got=%b want=%b", obs(0), expv(0));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q[3];
        logic [23:0] got;
        logic [23:0] want;
        logic        acc;
        int idx;
        int nb;
        int gaps;
        q = '{8'h01, 8'h80, 8'hFF};
        want = 24'b00000001_10000000_11111111;
        idx = 0;
        nb = 0;
        gaps = 0;
        got = '0;
        for (int c = 0; c < 60 && nb < 24; c++) begin
            total++;
            if (obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL b2b_model c=%0d got=%b want=%b", c, obs(0), expv(0));
            end
            if (dk0 === 1'b1 || nb > 0) begin
                if (dk0 !== 1'b1) gaps++;
                got = {got[22:0], out0};
                nb++;
            end
            v0 = (idx < 3);
            d0 = (idx < 3) ? q[idx] : 8'h00;
            acc = v0 && !mfull[0];
            tick();
            if (acc) idx++;
        end
        v0 = 1'b0;
        total++;
        if (got !== want || nb != 24) begin
            bad++;
            $display("FAIL b2b_stream got=%b n=%0d want=%b", got, nb, want);
        end
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=0", gaps);
        end
    endtask

    task automatic test_lsb();
        logic [7:0] pat;
        int n;
        n = 0;
        while (mfull[1] && n < 20) begin
            tick();
            n++;
        end
        v1 = 1'b1;
        d1 = 8'h0F;
        tick();
        v1 = 1'b0;
        n = 0;
        while (dk1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL lsb_wait got=timeout want=dk");
        end
        pat = 8'b11110000;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) pat = 8'b00111101;
            total++;
            if ({out1, dk1, sof1} !== {pat[7 - (i % 8)], i < 8, (i % 8) == 0}) begin
                bad++;
                $display("FAIL lsb_bits i=%0d got=%b want=%b", i,
                         {out1, dk1, sof1}, {pat[7 - (i % 8)], i < 8, (i % 8) == 0});
            end
            total++;
            if (obs(1) !== expv(1)) begin
                bad++;
                $display("FAIL lsb_model got=%b want=%b", obs(1), expv(1));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (mfull[0] && n < 20) begin
            tick();
            n++;
        end
        v0 = 1'b1;
        d0 = 8'hA5;
        tick();
        v0 = 1'b0;
        n = 0;
        while (!(mcdk[0] && mcur[0][7:0] == 8'hA5 && mp[0] == 0) && n < 20) begin
            tick();
            n++;
        end
        v0 = 1'b1;
        d0 = 8'h3C;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if ({dk0, rdy0} !== 2'b10 || mp[0] != 4) begin
            bad++;
            $display("FAIL rmid_setup got=%b cnt=%0d want=10 cnt=4", {dk0, rdy0}, mp[0]);
        end
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({out0, dk0, sof0, rdy0} !== 4'b1011) begin
            bad++;
            $display("FAIL rmid_async got=%b want=1011", {out0, dk0, sof0, rdy0});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            total++;
            if (dk0 !== 1'b0 || obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL rmid_after i=%0d got=%b want=%b", i, obs(0), expv(0));
            end
            tick();
        end
    endtask

    task automatic test_w10();
        logic [9:0] pat;
        int n;
        n = 0;
        while (mfull[2] && n < 20) begin
            tick();
            n++;
        end
        v2 = 1'b1;
        d2 = 10'h2AA;
        tick();
        v2 = 1'b0;
        n = 0;
        while (dk2 !== 1'b1 && n < 24) begin
            tick();
            n++;
        end
        total++;
        if (n >= 24) begin
            bad++;
            $display("FAIL w10_wait got=timeout want=dk");
        end
        pat = 10'b1010101010;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) pat = 10'b0101111100;
            total++;
            if ({out2, dk2, sof2} !== {pat[9 - (i % 10)], i < 10, (i % 10) == 0}) begin
                bad++;
                $display("FAIL w10_bits i=%0d got=%b want=%b", i,
                         {out2, dk2, sof2}, {pat[9 - (i % 10)], i < 10, (i % 10) == 0});
            end
            total++;
            if (obs(2) !== expv(2)) begin
                bad++;
                $display("FAIL w10_model got=%b want=%b", obs(2), expv(2));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs(d) !== expv(d)) begin
                    bad++;
                    $display("FAIL rand c=%0d u%0d got=%b want=%b", c, d, obs(d), expv(d));
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                total++;
                if ({dk0, sof0, rdy0, dk2, sof2, rdy2} !== 6'b011011) begin
                    bad++;
                    $display("FAIL rand_reset got=%b want=011011",
                             {dk0, sof0, rdy0, dk2, sof2, rdy2});
                end
                tick();
                reset = 1'b0;
            end
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            v2 = 1'($urandom_range(0, 3) != 0);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            d2 = 10'($urandom);
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        d0 = '0;
        d1 = '0;
        d2 = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb();
        test_reset_mid();
        test_w10();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
